// File: rtl/fc_pkg.sv
// Shared defaults, FSM state type and index-width helper for the FC input loader.
package fc_pkg;

    localparam int unsigned FC_WIDTH = 8;
    localparam int unsigned FC_IN    = 128;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fc_state_t;

    // Never returns zero, so a one-element vector still has a legal index register.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_frame_counter.sv
// Element index within the current frame, plus frame-complete and frame-length error detect.
module fc_frame_counter
    import fc_pkg::*;
#(
    parameter  int unsigned IN = FC_IN,
    localparam int unsigned IW = idx_w(IN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          last,
    output logic [IW-1:0] idx,
    output logic          frame_done,
    output logic          short_err,
    output logic          len_err
);

    logic at_end;

    assign at_end     = (idx == IW'(IN - 1));
    assign frame_done = inc && at_end;
    assign short_err  = inc && last && !at_end;
    // Early s_last and a missing s_last on the final element are both length errors.
    assign len_err    = inc && (last != at_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (inc) begin
            if (at_end || last) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_in_loader.sv
// Serial-to-parallel activation loader feeding an FC layer.
// Define FC_IN_LOADER_PINGPONG_EN for two alternating buffers; default is a single buffer.
module fc_in_loader
    import fc_pkg::*;
#(
    parameter int unsigned WIDTH = FC_WIDTH,
    parameter int unsigned IN    = FC_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_len
);

    localparam int unsigned IW = idx_w(IN);

    logic          s_ready_int;
    logic          s_hs;
    logic          v_hs;
    logic [IW-1:0] idx;
    logic          frame_done;
    logic          short_err;
    logic          len_err;

    // s_ready is forced low while reset is asserted, high as soon as it releases.
    assign s_ready = s_ready_int && rst_n;
    assign s_hs    = s_valid && s_ready;
    assign v_hs    = x_valid && x_ready;

    fc_frame_counter #(
        .IN (IN)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (s_hs),
        .last       (s_last),
        .idx        (idx),
        .frame_done (frame_done),
        .short_err  (short_err),
        .len_err    (len_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else begin
            err_len <= len_err;
        end
    end

`ifdef FC_IN_LOADER_PINGPONG_EN

    fc_state_t        bstate     [2];
    fc_state_t        bstate_nxt [2];
    logic             wsel;
    logic             rsel;
    logic [WIDTH-1:0] mem [2][0:IN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate[0] <= FILL;
            bstate[1] <= FILL;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
        end else begin
            bstate[0] <= bstate_nxt[0];
            bstate[1] <= bstate_nxt[1];
            if (frame_done) wsel <= ~wsel;
            if (v_hs)       rsel <= ~rsel;
        end
    end

    // Fill and drain pointers each toggle on their own handshake, so frames leave in arrival order
    // and a drain plus a completion in the same cycle simply swap the two buffers.
    always_comb begin
        s_ready_int   = (bstate[wsel] == FILL);
        x_valid       = (bstate[rsel] == HOLD);
        bstate_nxt[0] = bstate[0];
        bstate_nxt[1] = bstate[1];
        for (int unsigned b = 0; b < 2; b++) begin
            if (frame_done && (wsel == b[0])) bstate_nxt[b] = HOLD;
            if (v_hs && (rsel == b[0]))       bstate_nxt[b] = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (s_hs && !short_err) begin
            mem[wsel][idx] <= s_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < IN; k++) begin
            x[k] = mem[rsel][k];
        end
    end

`else

    fc_state_t        state;
    fc_state_t        state_nxt;
    logic [WIDTH-1:0] mem [0:IN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        s_ready_int = 1'b0;
        x_valid     = 1'b0;
        case (state)
            FILL: begin
                s_ready_int = 1'b1;
                if (frame_done) state_nxt = HOLD;
            end
            HOLD: begin
                x_valid = 1'b1;
                if (x_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_hs && !short_err) begin
            mem[idx] <= s_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < IN; k++) begin
            x[k] = mem[k];
        end
    end

`endif

endmodule

// File: tb/tb_fc_in_loader.sv
// Directed self-checking bench for fc_in_loader (single-buffer or FC_IN_LOADER_PINGPONG_EN build).
module tb_fc_in_loader;

    localparam int W = 8;
    localparam int N = 128;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic [W-1:0] x [0:N-1];
    logic         x_valid;
    logic         x_ready;
    logic         err_len;

    int nassert  = 0;
    int nfail    = 0;
    int err_seen = 0;
    logic [W-1:0] expv [0:N-1];

    fc_in_loader #(
        .WIDTH (W),
        .IN    (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .err_len (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_len === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [W-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int stride, input int last_at);
        for (int k = 0; k < N; k++) begin
            expv[k] = W'(base + stride * k);
            send_elem(expv[k], k == last_at);
        end
    endtask

    task automatic check_x(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (x[k] !== expv[k]) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        x_ready = 1'b0;
        step();
        step();
        check("rst_s_ready_low", s_ready, 1'b0);
        check("rst_x_valid",     x_valid, 1'b0);
        check("rst_err_len",     err_len, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_s_ready", s_ready, 1'b1);

`ifdef FC_IN_LOADER_PINGPONG_EN
        begin
            int drops;
            int frames;
            int bad1;
            int bad2;
            drops  = 0;
            frames = 0;
            bad1   = 0;
            bad2   = 0;
            x_ready = 1'b1;
            for (int k = 0; k < 2 * N; k++) begin
                if (s_ready !== 1'b1) drops++;
                send_elem((k < N) ? W'(1) : W'(2), (k == N - 1) || (k == 2 * N - 1));
                if (x_valid === 1'b1) begin
                    for (int j = 0; j < N; j++) begin
                        if (frames == 0 && x[j] !== W'(1)) bad1++;
                        if (frames == 1 && x[j] !== W'(2)) bad2++;
                    end
                    frames++;
                end
            end
            check("pp_last_x_valid", x_valid, 1'b1);
            check("pp_s_ready_drops", drops, 0);
            check("pp_frame1_all1", bad1, 0);
            check("pp_frame2_all2", bad2, 0);
            check("pp_frames_seen", frames, 2);
            step();
            check("pp_drained", x_valid, 1'b0);
            check("pp_no_err", err_seen, 0);
            x_ready = 1'b0;
        end
`else
        // Full frame k = 0..127 held with x_ready low
        send_frame(0, 1, N - 1);
        check("f1_x_valid", x_valid, 1'b1);
        check("f1_s_ready", s_ready, 1'b0);
        check_x("f1_x_contents");
        check("f1_no_err", err_seen, 0);

        // Upstream pushes 0xFF while held; nothing may be accepted
        s_valid = 1'b1;
        s_data  = 8'hFF;
        repeat (10) step();
        check("hold_x_valid", x_valid, 1'b1);
        check("hold_s_ready", s_ready, 1'b0);
        check_x("hold_x_stable");
        x_ready = 1'b1;
        step();
        s_valid = 1'b0;
        x_ready = 1'b0;
        check("drain_s_ready", s_ready, 1'b1);
        check("drain_x_valid", x_valid, 1'b0);

        // Short frame: s_last on index 5
        for (int k = 0; k < 6; k++) send_elem(8'h11, k == 5);
        check("short_err_pulse", err_len, 1'b1);
        check("short_x_valid",   x_valid, 1'b0);
        check("short_s_ready",   s_ready, 1'b1);
        step();
        check("short_err_clear", err_len, 1'b0);
        send_frame(8'hA5, 0, N - 1);
        check("a5_x_valid", x_valid, 1'b1);
        check_x("a5_x_contents");
        check("a5_err_count", err_seen, 1);
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;

        // Long frame: no s_last on the final element
        send_frame(3, 7, -1);
        check("long_x_valid", x_valid, 1'b1);
        check("long_err_len", err_len, 1'b1);
        check_x("long_x_contents");
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
        check("long_err_count", err_seen, 2);
        check("long_err_clear", err_len, 1'b0);

        // Reset after 60 elements discards the partial frame
        for (int k = 0; k < 60; k++) send_elem(8'h77, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x_valid", x_valid, 1'b0);
        check("mid_rst_s_ready", s_ready, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rel_s_ready", s_ready, 1'b1);
        send_frame(8'h40, 1, N - 1);
        check("post_rst_x_valid", x_valid, 1'b1);
        check_x("post_rst_x_contents");
        check("post_rst_err_count", err_seen, 2);

        // x_ready held high across a whole fill must not disturb it
        x_ready = 1'b1;
        step();
        check("xr_drain_s_ready", s_ready, 1'b1);
        send_frame(8'hC0, 255, N - 1);
        check("xr_x_valid", x_valid, 1'b1);
        check_x("xr_x_contents");
        step();
        check("xr_drained", x_valid, 1'b0);
        check("xr_s_ready", s_ready, 1'b1);
        x_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
